music_box_player: RTL and testbench
===================================

MUSIC_BOX_PLAYER -- requirements
Module: music_box_player

Interface
REQ-001 Parameter BEAT_CYCLES, default 12000000, clk cycles per beat at normal tempo (0.25 s at 48 MHz).
REQ-002 Parameter GAP_CYCLES, default 480000, silent articulation gap after every note (10 ms).
REQ-003 clk  in  1  system clock, 48 MHz, all logic on the rising edge.
REQ-004 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 start  in  1  one-cycle pulse; begins playback from entry 0.
REQ-006 stop  in  1  one-cycle pulse; aborts playback.
REQ-007 loop_en  in  1  level; restart from entry 0 at end of song.
REQ-008 tempo_sel  in  2  0/3 normal (BEAT_CYCLES), 1 fast (BEAT_CYCLES/2), 2 slow (2*BEAT_CYCLES).
REQ-009 note  out  6  note code to the buzzer stage: 0 rest; 1..48 = semitone within 4 octaves (octave = (note-1)/12 + 1).
REQ-010 stat  out  1  1 = music-box mode (buzzer follows note), 0 = piano mode.
REQ-011 busy  out  1  playback in progress.
REQ-012 song_end  out  1  one-cycle pulse at natural end of song (not on stop).
REQ-013 note_idx  out  6  index of entry currently loaded or playing.

Function
REQ-014 Song stored in an internal constant table, up to 64 entries of {note[5:0], dur[3:0]}, dur in beats; dur = 0 is the end-of-song terminator.
REQ-015 Table entries 0..7 shall be: (13,1)(13,1)(20,1)(20,1)(22,1)(22,1)(20,2)(0,0); further entries are unreachable.
REQ-016 State machine IDLE, LOAD, PLAY, GAP; LOAD lasts exactly 1 cycle, PLAY exactly dur*beat cycles, GAP exactly GAP_CYCLES cycles.
REQ-017 IDLE: start=1 -> LOAD with note_idx=0; start while not IDLE is ignored.
REQ-018 LOAD: table[note_idx] read and registered; tempo_sel sampled and the beat length latched for this entry only.
REQ-019 LOAD with dur != 0 -> PLAY; note = entry note from the first PLAY cycle for the full PLAY duration.
REQ-020 PLAY -> GAP after dur*beat cycles; note = 0 throughout GAP.
REQ-021 GAP end -> LOAD with note_idx+1; note_idx wraps 63 -> 0.
REQ-022 LOAD with dur = 0: loop_en=1 and note_idx != 0 -> LOAD with note_idx=0 (no song_end); otherwise -> IDLE with song_end=1 for the first IDLE cycle.
REQ-023 Terminator at entry 0 shall never loop; it ends the song per REQ-022.
REQ-024 Beat counter 26 bits wide; remaining-beat counter 4 bits; no counter shall overflow for any legal tempo_sel.
REQ-025 busy = stat = 1 in LOAD, PLAY, GAP; 0 in IDLE; note = 0 in LOAD and IDLE.
REQ-026 stop=1 in any state -> IDLE next cycle: note=0, stat=0, busy=0, note_idx=0, song_end=0; stop and start in the same cycle: stop wins.
REQ-027 tempo_sel changes mid-note take effect at the next LOAD only.

Reset
REQ-028 rst_n low asynchronously forces IDLE, note=0, stat=0, busy=0, song_end=0, note_idx=0, all counters 0.
REQ-029 rst_n asserted mid-note silences the output immediately; release returns to IDLE awaiting start.

Verification (BEAT_CYCLES=10, GAP_CYCLES=2)
REQ-030 start at edge T, loop_en=0, tempo_sel=0 -> busy=1 at T+1, note=13 from T+2 for 10 cycles, note=0 for 2 cycles, note_idx=1 at T+14.
REQ-031 Same stimulus, full song -> entry 6 note=20 held 20 cycles; song_end single pulse at T+103, busy=0 from T+103; note/stat 0 thereafter.
REQ-032 loop_en=1 -> after entry 6 GAP, one terminator LOAD then note_idx=0, note=13 again; no song_end; busy stays 1.
REQ-033 tempo_sel=1 from start -> each 1-beat note held 5 cycles; switching to 2 mid-entry-2 gives entry 3 held 20 cycles, entry 2 unchanged.
REQ-034 stop during PLAY of entry 3 -> next cycle note=0, stat=0, busy=0, note_idx=0, no song_end; start+stop same cycle in IDLE -> stays IDLE.
REQ-035 rst_n low for 1 cycle mid-PLAY -> outputs 0 asynchronously; subsequent start replays from entry 0 with REQ-030 timing.

Source files
------------

// File: rtl/music_box_player.sv
// Music-box sequencer: walks a constant song table and drives a note code
// to the buzzer stage, with tempo selection, looping and articulation gaps.
module music_box_player #(
  parameter int unsigned BEAT_CYCLES = 12000000,
  parameter int unsigned GAP_CYCLES  = 480000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [1:0] tempo_sel,
  output logic [5:0] note,
  output logic       stat,
  output logic       busy,
  output logic       song_end,
  output logic [5:0] note_idx
);

  localparam int unsigned CNT_W  = 26;
  localparam int unsigned NOTE_W = 6;
  localparam int unsigned DUR_W  = 4;
  localparam int unsigned IDX_W  = 6;

  // Fast tempo never drops below one cycle per beat, so the reload value stays valid.
  localparam int unsigned BEAT_HALF = (BEAT_CYCLES / 2 == 0) ? 1 : BEAT_CYCLES / 2;
  localparam int unsigned GAP_LEN   = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam logic [CNT_W-1:0] BEAT_NORM = CNT_W'(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] BEAT_FAST = CNT_W'(BEAT_HALF);
  localparam logic [CNT_W-1:0] BEAT_SLOW = CNT_W'(2 * BEAT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  typedef struct packed {
    logic [NOTE_W-1:0] pitch;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_t;

  // Song table; every entry past the terminator reads as another terminator.
  function automatic entry_t song_rom(input logic [IDX_W-1:0] idx);
    entry_t e;
    case (idx)
      6'd0:    e = '{pitch: 6'd13, dur: 4'd1};
      6'd1:    e = '{pitch: 6'd13, dur: 4'd1};
      6'd2:    e = '{pitch: 6'd20, dur: 4'd1};
      6'd3:    e = '{pitch: 6'd20, dur: 4'd1};
      6'd4:    e = '{pitch: 6'd22, dur: 4'd1};
      6'd5:    e = '{pitch: 6'd22, dur: 4'd1};
      6'd6:    e = '{pitch: 6'd20, dur: 4'd2};
      default: e = '{pitch: 6'd0,  dur: 4'd0};
    endcase
    return e;
  endfunction

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   beat_len, beat_len_n;
  logic [DUR_W-1:0]   beats_left, beats_left_n;
  logic [NOTE_W-1:0]  note_n;
  logic [IDX_W-1:0]   idx_n;
  logic               song_end_n;
  logic               busy_n;
  logic [CNT_W-1:0]   tempo_len;
  entry_t             rom;

  assign rom = song_rom(note_idx);

  always_comb begin
    case (tempo_sel)
      2'd1:    tempo_len = BEAT_FAST;
      2'd2:    tempo_len = BEAT_SLOW;
      default: tempo_len = BEAT_NORM;
    endcase
  end

  // Next-state and next-output logic; cnt counts beat cycles in PLAY and gap cycles in GAP.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    beat_len_n   = beat_len;
    beats_left_n = beats_left;
    note_n       = note;
    idx_n        = note_idx;
    song_end_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        note_n = '0;
        if (start) begin
          state_n = ST_LOAD;
          idx_n   = '0;
        end
      end
      ST_LOAD: begin
        note_n     = '0;
        beat_len_n = tempo_len;
        if (rom.dur != '0) begin
          state_n      = ST_PLAY;
          note_n       = rom.pitch;
          cnt_n        = tempo_len - CNT_W'(1);
          beats_left_n = rom.dur - DUR_W'(1);
        end else if (loop_en && (note_idx != '0)) begin
          state_n = ST_LOAD;
          idx_n   = '0;
        end else begin
          state_n    = ST_IDLE;
          idx_n      = '0;
          song_end_n = 1'b1;
        end
      end
      ST_PLAY: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (beats_left != '0) begin
          beats_left_n = beats_left - DUR_W'(1);
          cnt_n        = beat_len - CNT_W'(1);
        end else begin
          state_n = ST_GAP;
          note_n  = '0;
          cnt_n   = GAP_LAST;
        end
      end
      ST_GAP: begin
        note_n = '0;
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = ST_LOAD;
          idx_n   = note_idx + IDX_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        note_n  = '0;
        idx_n   = '0;
      end
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (stop) begin
      state_n      = ST_IDLE;
      note_n       = '0;
      idx_n        = '0;
      song_end_n   = 1'b0;
      cnt_n        = '0;
      beats_left_n = '0;
    end

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      beat_len   <= '0;
      beats_left <= '0;
      note       <= '0;
      stat       <= 1'b0;
      busy       <= 1'b0;
      song_end   <= 1'b0;
      note_idx   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      beat_len   <= beat_len_n;
      beats_left <= beats_left_n;
      note       <= note_n;
      stat       <= busy_n;
      busy       <= busy_n;
      song_end   <= song_end_n;
      note_idx   <= idx_n;
    end
  end

endmodule

// File: tb/tb_music_box_player.sv
// Bench for music_box_player: timeline-expansion reference model, directed
// literal checks on the song timing, then randomized control stimulus.
module tb_music_box_player;

  localparam int unsigned BEAT = 10;
  localparam int unsigned GAP  = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [1:0] tempo_sel;
  logic [5:0] note;
  logic       stat;
  logic       busy;
  logic       song_end;
  logic [5:0] note_idx;

  music_box_player #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .tempo_sel(tempo_sel), .note(note), .stat(stat), .busy(busy),
    .song_end(song_end), .note_idx(note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: on each LOAD the whole entry is expanded into a queue
  // of future per-cycle outputs.
  typedef struct {
    int n;
    int idx;
    bit load;
  } item_t;

  item_t q[$];
  int    exp_note, exp_idx;
  bit    exp_busy, exp_end;
  bit    m_load;
  int    m_idx;

  int song_pitch [0:7] = '{13, 13, 20, 20, 22, 22, 20, 0};
  int song_dur   [0:7] = '{1, 1, 1, 1, 1, 1, 2, 0};

  function automatic int beat_of(input logic [1:0] t);
    if (t == 2'd1) return BEAT / 2;
    if (t == 2'd2) return 2 * BEAT;
    return BEAT;
  endfunction

  task automatic model_idle();
    exp_note = 0; exp_idx = 0; exp_busy = 0; m_load = 0;
    q.delete();
  endtask

  task automatic model_edge();
    item_t it;
    int p, d, len;
    exp_end = 0;
    if (stop) begin
      model_idle();
    end else if (q.size() > 0) begin
      it = q.pop_front();
      exp_note = it.n; exp_idx = it.idx; exp_busy = 1; m_load = it.load;
      if (it.load) m_idx = it.idx;
    end else if (m_load) begin
      p = (m_idx < 8) ? song_pitch[m_idx] : 0;
      d = (m_idx < 8) ? song_dur[m_idx] : 0;
      m_load = 0;
      if (d != 0) begin
        len = d * beat_of(tempo_sel);
        exp_note = p; exp_idx = m_idx; exp_busy = 1;
        for (int i = 1; i < len; i++) q.push_back('{n: p, idx: m_idx, load: 1'b0});
        for (int i = 0; i < int'(GAP); i++) q.push_back('{n: 0, idx: m_idx, load: 1'b0});
        q.push_back('{n: 0, idx: (m_idx + 1) % 64, load: 1'b1});
      end else if (loop_en && m_idx != 0) begin
        m_idx = 0; m_load = 1;
        exp_note = 0; exp_idx = 0; exp_busy = 1;
      end else begin
        model_idle();
        exp_end = 1;
      end
    end else if (!exp_busy && start) begin
      m_load = 1; m_idx = 0;
      exp_note = 0; exp_idx = 0; exp_busy = 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_all();
    chk("note", int'(note), exp_note);
    chk("stat", int'(stat), int'(exp_busy));
    chk("busy", int'(busy), int'(exp_busy));
    chk("song_end", int'(song_end), int'(exp_end));
    chk("note_idx", int'(note_idx), exp_idx);
  endtask

  // Called right after a falling edge: drive, clock, update model, compare.
  task automatic step(input logic s, input logic sp, input logic lp, input logic [1:0] tp);
    start = s; stop = sp; loop_en = lp; tempo_sel = tp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_pulse();
    start = 1'b0; stop = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_note", int'(note), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_stat", int'(stat), 0);
    model_idle();
    exp_end = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  logic       r_loop;
  logic [1:0] r_tempo;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; tempo_sel = 2'd0;
    model_idle(); exp_end = 0; m_idx = 0;
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Full song at normal tempo, no loop.
    step(1, 0, 0, 0);
    chk("lit_busy_k0", int'(busy), 1);
    for (int k = 1; k <= 105; k++) begin
      step(0, 0, 0, 0);
      case (k)
        1:   chk("lit_note_first", int'(note), 13);
        10:  chk("lit_note_last", int'(note), 13);
        11:  chk("lit_gap_note", int'(note), 0);
        13:  chk("lit_idx1", int'(note_idx), 1);
        79:  chk("lit_e6_first", int'(note), 20);
        98:  chk("lit_e6_last", int'(note), 20);
        99:  chk("lit_e6_gap", int'(note), 0);
        101: chk("lit_end_not_yet", int'(song_end), 0);
        102: begin
          chk("lit_song_end", int'(song_end), 1);
          chk("lit_busy_end", int'(busy), 0);
        end
        103: chk("lit_song_end_pulse", int'(song_end), 0);
        default: ;
      endcase
    end

    // Looping: terminator LOAD, then entry 0 again.
    step(1, 0, 1, 0);
    for (int k = 1; k <= 105; k++) begin
      step(0, 0, 1, 0);
      if (k == 102) begin
        chk("lit_loop_idx0", int'(note_idx), 0);
        chk("lit_loop_busy", int'(busy), 1);
        chk("lit_loop_noend", int'(song_end), 0);
      end
      if (k == 103) chk("lit_loop_note", int'(note), 13);
    end
    step(0, 1, 0, 0);
    chk("lit_stop_busy", int'(busy), 0);

    // Fast tempo: one-beat notes last 5 cycles.
    step(1, 0, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0, 1);
      if (k == 5) chk("lit_fast_last", int'(note), 13);
      if (k == 6) chk("lit_fast_gap", int'(note), 0);
    end
    step(0, 1, 0, 0);

    // Start and stop together in IDLE stays idle.
    step(1, 1, 0, 0);
    chk("lit_startstop_idle", int'(busy), 0);

    // Reset mid-PLAY, then replay with nominal timing.
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    reset_pulse();
    step(1, 0, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      step(0, 0, 0, 0);
      if (k == 1) chk("lit_replay_note", int'(note), 13);
      if (k == 13) chk("lit_replay_idx", int'(note_idx), 1);
    end

    // Randomized control traffic.
    r_loop = 1'b0; r_tempo = 2'd0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 199) == 0) r_loop = ~r_loop;
      if ($urandom_range(0, 29) == 0) r_tempo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) begin
        reset_pulse();
      end else begin
        step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 299) == 0),
             r_loop, r_tempo);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
